// File: rtl/int_mul_serial_pkg.sv
// int_mul_serial_pkg: shared state encoding and sizing helpers for the serial multiplier
package int_mul_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of W-bit digits needed to cover an N-bit operand
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Digit counter width; a single-digit multiplier still keeps a 1-bit counter
    function automatic int cnt_width(input int l);
        return (l > 1) ? $clog2(l) : 1;
    endfunction

endpackage

// File: rtl/int_mul_digit.sv
// int_mul_digit: one N x W partial product shifted into place and added to the 2N-bit accumulator
module int_mul_digit #(
    parameter int N  = 32,
    parameter int W  = 16,
    parameter int CW = 1
) (
    input  logic [N-1:0]   a_i,
    input  logic [W-1:0]   d_i,
    input  logic [CW-1:0]  cnt_i,
    input  logic [2*N-1:0] acc_i,
    output logic [2*N-1:0] acc_o
);

    logic [N+W-1:0] pp;

    // The shifted partial product never carries past bit 2N-1 because the top digit is zero-extended
    always_comb begin
        pp    = {{W{1'b0}}, a_i} * {{N{1'b0}}, d_i};
        acc_o = acc_i + ((2*N)'(pp) << (cnt_i * W));
    end

endmodule

// File: rtl/int_mul_serial.sv
// int_mul_serial: digit-serial unsigned N x N multiplier with valid/ready handshake on both sides
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef W_SIZE
`define W_SIZE 16
`endif

module int_mul_serial
    import int_mul_serial_pkg::*;
#(
    parameter int DATA_SIZE = `DATA_SIZE_ARB,
    parameter int W_SIZE    = `W_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_SIZE-1:0]   A,
    input  logic [DATA_SIZE-1:0]   B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DATA_SIZE-1:0] P
);

    localparam int N      = DATA_SIZE;
    localparam int W      = W_SIZE;
    localparam int L_SIZE = ceil_div(N, W);
    localparam int LW     = L_SIZE * W;
    localparam int CW     = cnt_width(L_SIZE);

    state_e         state_q;
    logic [N-1:0]   a_q;
    logic [LW-1:0]  b_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] acc_d;
    logic [CW-1:0]  cnt_q;
    logic           out_valid_q;
    logic           accept;
    logic           last;

    // Ready in IDLE, or in DONE when the result is being taken this cycle; never during reset
    always_comb begin
        in_ready = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
        accept   = in_ready && in_valid;
        last     = cnt_q == CW'(L_SIZE - 1);
    end

    int_mul_digit #(
        .N  (N),
        .W  (W),
        .CW (CW)
    ) u_digit (
        .a_i   (a_q),
        .d_i   (b_q[W-1:0]),
        .cnt_i (cnt_q),
        .acc_i (acc_q),
        .acc_o (acc_d)
    );

    // FSM: an accept always restarts the operation, otherwise step digits or wait for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state_q     <= MUL;
            a_q         <= A;
            b_q         <= LW'(B);
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MUL: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> W;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                IDLE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign P         = acc_q;

endmodule

// File: tb/tb_int_mul_serial.sv
// tb_int_mul_serial: scoreboard bench for two multiplier instances (W=16 directed, W=12 directed plus random)
`timescale 1ns/1ps
module tb_int_mul_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv0, ir0, ov0, or0;
    logic [31:0] a0, b0;
    logic [63:0] p0;
    logic        iv1, ir1, ov1, or1;
    logic [31:0] a1, b1;
    logic [63:0] p1;

    int_mul_serial #(.DATA_SIZE(32), .W_SIZE(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .out_valid(ov0), .out_ready(or0), .P(p0)
    );

    int_mul_serial #(.DATA_SIZE(32), .W_SIZE(12)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .out_valid(ov1), .out_ready(or1), .P(p1)
    );

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int checks = 0;
    int errors = 0;
    int acc1 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        int s;
        s = $urandom_range(7);
        return (s == 0) ? 32'h0 : (s == 1) ? 32'hFFFF_FFFF : 32'($urandom);
    endfunction

    // Scoreboard for instance 0: push on accept, pop on consumed output
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) q0.delete();
        else begin
            if (ov0 && or0) begin
                e = (q0.size() != 0) ? q0.pop_front() : ~p0;
                check("p0", p0, e);
            end
            if (iv0 && ir0) q0.push_back(64'(a0) * 64'(b0));
        end
    end

    // Scoreboard for instance 1
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) q1.delete();
        else begin
            if (ov1 && or1) begin
                e = (q1.size() != 0) ? q1.pop_front() : ~p1;
                check("p1", p1, e);
            end
            if (iv1 && ir1) begin
                q1.push_back(64'(a1) * 64'(b1));
                acc1++;
            end
        end
    end

    task automatic send0(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        iv0 = 1'b1;
        a0 = a;
        b0 = b;
        @(negedge clk);
        while (!ir0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept0", 64'(ir0), 64'd1);
        @(posedge clk);
        #1 iv0 = 1'b0;
    endtask

    task automatic lat0(input int exp_lat, input logic [63:0] exp_p);
        int n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!ov0 && n < 20);
        check("lat0", 64'(n), 64'(exp_lat));
        check("p0_const", p0, exp_p);
    endtask

    task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp_p);
        send0(a, b);
        lat0(2, exp_p);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold;
        int seen;
        int n;
        int cyc;
        iv0 = 0; or0 = 1; a0 = 0; b0 = 0;
        iv1 = 0; or1 = 1; a1 = 0; b1 = 0;
        repeat (3) @(negedge clk);
        check("rst_ov0", 64'(ov0), 0);
        check("rst_p0", p0, 0);
        check("rst_ir0", 64'(ir0), 0);
        check("rst_ov1", 64'(ov1), 0);
        check("rst_p1", p1, 0);
        check("rst_ir1", 64'(ir1), 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ir0", 64'(ir0), 1);
            check("idle_ov0", 64'(ov0), 0);
        end
        @(posedge clk);
        #1;
        run0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run0(32'h1234_5678, 32'h0, 64'h0);
        run0(32'h1, 32'h8000_0000, 64'h0000_0000_8000_0000);
        run0(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        or0 = 1'b0;
        send0(32'd7, 32'd9);
        lat0(2, 64'd63);
        hold = p0;
        iv0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
        repeat (5) begin
            @(negedge clk);
            check("bp_p", p0, hold);
            check("bp_ov", 64'(ov0), 1);
            check("bp_ir", 64'(ir0), 0);
        end
        @(posedge clk);
        #1 or0 = 1'b1;
        @(posedge clk);
        #1 iv0 = 1'b0;
        check("no_bubble_ir", 64'(ir0), 0);
        check("no_bubble_ov", 64'(ov0), 0);
        lat0(2, 64'd15);
        @(posedge clk);
        #1;
        send0(32'd11, 32'd13);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= int'(ov0);
        end
        check("rst_mid_ov", 64'(seen), 0);
        @(posedge clk);
        #1;
        run0(32'd6, 32'd7, 64'd42);
        iv1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
        n = 0;
        @(negedge clk);
        while (!ir1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 iv1 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!ov1 && n < 20);
        check("lat1", 64'(n), 64'd3);
        check("p1_const", p1, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk);
        #1;
        acc1 = 0;
        cyc = 0;
        while (acc1 < 10000 && cyc < 80000) begin
            iv1 = $urandom_range(9) != 0;
            a1 = pick();
            b1 = pick();
            or1 = $urandom_range(3) != 0;
            @(posedge clk);
            #1 cyc++;
        end
        check("rand_accepts", 64'(acc1), 64'd10000);
        iv1 = 1'b0;
        or1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain1", 64'(q1.size()), 0);
        check("drain0", 64'(q0.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_mul_serial.md
# int_mul_serial

Digit-serial integer multiplier that produces the 2N-bit product consumed by the modular reduction stage (the `P` input of the NTT butterfly's reduction path). It takes two N-bit residues, multiplies A by B one W-bit digit of B per cycle, and presents the full 2N-bit product under a valid/ready handshake. It replaces a fully combinational N×N multiplier where area matters more than throughput.

## Interface
Parameters:
- `DATA_SIZE`, default `` `DATA_SIZE_ARB ``: operand width N.
- `W_SIZE`, default `` `W_SIZE ``: digit width W; 1 ≤ W ≤ N.
- `L_SIZE`, derived: ceil(N/W); number of digit cycles. Not overridable.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands A and B are valid.
- `in_ready`  out  1: block accepts operands this cycle.
- `A`  in  N: multiplicand, unsigned.
- `B`  in  N: multiplier, unsigned; consumed LSB digit first.
- `out_valid`  out  1: `P` holds a finished product.
- `out_ready`  in  1: downstream takes `P` this cycle.
- `P`  out  2N: unsigned product A·B, exact, no reduction.

## Operation
- States: IDLE, MUL, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch A, latch B zero-extended to L·W bits, clear accumulator, clear digit counter `cnt`, go to MUL.
- MUL: each cycle, acc ← acc + (A · B[cnt·W +: W]) << (cnt·W), then `cnt` ← `cnt`+1. After the step with `cnt` = L−1, go to DONE. `in_ready`=0 in MUL.
- Accumulator is 2N bits. The zero-extended top digit guarantees that no carry leaves bit 2N−1; no wrap-around occurs.
- DONE: `out_valid`=1, `P` = acc. `P` stays stable while `out_valid`=1 and `out_ready`=0.
- In DONE, `in_ready` = `out_ready` (combinational). When `out_ready`=1:
  - if `in_valid`=1, the new operands are accepted in the same cycle and the block goes to MUL;
  - otherwise the block goes to IDLE.
- Inputs `A` and `B` are sampled only on an accept; they are don't-care at all other times.
- `in_valid` must not be gated by `in_ready`. A producer that holds `in_valid` during MUL is simply stalled.

## Timing
- Reset: `in_ready`=0 while `rst_n`=0 and 1 afterwards in IDLE. `out_valid`=0 and `P`=0 at reset; state IDLE; `cnt`=0.
- Latency: accept on edge k, MUL steps on edges k+1 … k+L, `out_valid` high after edge k+L.
- Throughput: one product per L+1 cycles when `out_ready` is held at 1 and back-to-back accept in DONE is used.
- Reset mid-MUL or mid-DONE: the product is discarded, `out_valid` drops immediately, and no partial result is ever presented.
- L=1 (W=N): MUL lasts one cycle; latency 1.

## Structure
- Shared defines/package: state encoding (IDLE/MUL/DONE), the `L_SIZE` ceil-divide constant, and the `cnt` width clog2(L_SIZE), with a minimum of 1.
- One sub-module, `int_mul_digit`: combinational N×W multiply plus 2N-bit shifted accumulate.
- The top level holds the FSM, the operand registers, `cnt`, and the handshake logic.

## Test plan
All scenarios use N=32, W=16 (L=2) unless stated otherwise.
- Reset and idle: hold `rst_n`=0 → `out_valid`=0, `P`=0; release reset → `in_ready`=1, `out_valid` stays 0 with no input.
- Max operands: A=B=0xFFFFFFFF accepted on edge k → `out_valid` after edge k+2, `P`=0xFFFFFFFE00000001.
- Corner values: A=0x12345678, B=0 → `P`=0. A=1, B=0x80000000 → `P`=0x0000000080000000. A=B=0x00010000 → `P`=0x0000000100000000.
- Backpressure: with `out_ready`=0 for 5 cycles, `P` and `out_valid` are stable and `in_ready`=0. Raise `out_ready` with `in_valid`=1, A=3, B=5 → next product `P`=15 appears after 2 more edges with no IDLE bubble.
- Reset mid-MUL: assert `rst_n`=0 one cycle after accept → `out_valid` never rises for that operation; the next accept gives the correct product.
- Uneven digits, N=32, W=12 (L=3, B extended to 36 bits): A=B=0xFFFFFFFF → `P`=0xFFFFFFFE00000001, `out_valid` 3 edges after accept; plus 10k random operand pairs with random `out_ready` checked against a reference model.
